// File: rtl/spi_master_param.sv
// Parameterised full-duplex SPI master.
// Features: programmable SCLK divider, all four CPOL/CPHA modes, one-hot
// active-low chip selects, and MSB- or LSB-first bit order.
// Handshake: start/busy/done. Every output is driven from a register.
module spi_master_param #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CS = 3,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned DIV    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic              lsb_first,
   input  logic [SEL_W-1:0]  cs_sel,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              miso,
   output logic              sclk,
   output logic              mosi,
   output logic [NUM_CS-1:0] cs_n,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned EDGES  = 2 * DATA_W;
   localparam int unsigned EDGE_W = $clog2(EDGES + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES);
   localparam logic [EDGE_W-1:0] EDGE_PEN  = EDGE_W'(EDGES - 2);
   localparam logic [EDGE_W-1:0] EDGE_3    = EDGE_W'(3);
   localparam logic [SEL_W:0]    CS_COUNT  = (SEL_W + 1)'(NUM_CS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEAD  = 2'd1,
      XFER  = 2'd2,
      TRAIL = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [EDGE_W-1:0]   edge_q, edge_d;
   logic [EDGE_W-1:0]   edge_num;
   logic                cpol_q, cpol_d;
   logic                cpha_q, cpha_d;
   logic                lsb_q, lsb_d;
   logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;

   logic                sclk_d;
   logic                mosi_d;
   logic [NUM_CS-1:0]   cs_n_d;
   logic [DATA_W-1:0]   rx_data_d;
   logic                busy_d;
   logic                done_d;
   logic                err_d;

   // Next-state and next-output logic for the transfer sequencer
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      edge_d    = edge_q;
      edge_num  = edge_q + EDGE_W'(1);
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      lsb_d     = lsb_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      sclk_d    = sclk;
      mosi_d    = mosi;
      cs_n_d    = cs_n;
      rx_data_d = rx_data;
      busy_d    = busy;
      done_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if ({1'b0, cs_sel} < CS_COUNT) begin
                  state_d = LEAD;
                  div_d   = '0;
                  edge_d  = '0;
                  cpol_d  = mode[1];
                  cpha_d  = mode[0];
                  lsb_d   = lsb_first;
                  tx_sr_d = tx_data;
                  rx_sr_d = '0;
                  sclk_d  = mode[1];
                  mosi_d  = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                  cs_n_d  = ~(NUM_CS'(1) << cs_sel);
                  busy_d  = 1'b1;
               end else begin
                  // Out-of-range slave: report and stay idle, pins untouched
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end
            end
         end

         LEAD: begin
            if (div_q == DIV_LAST) begin
               state_d = XFER;
               div_d   = '0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         XFER: begin
            if (div_q == DIV_LAST) begin
               div_d  = '0;
               edge_d = edge_num;
               sclk_d = ~sclk;
               // Odd edges sample when CPHA=0, even edges when CPHA=1
               if (edge_num[0] != cpha_q) begin
                  rx_sr_d = lsb_q ? {miso, rx_sr_q[DATA_W-1:1]}
                                  : {rx_sr_q[DATA_W-2:0], miso};
               end else if (cpha_q ? (edge_num >= EDGE_3) : (edge_num <= EDGE_PEN)) begin
                  tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
                  mosi_d  = lsb_q ? tx_sr_q[1] : tx_sr_q[DATA_W-2];
               end
               if (edge_num == EDGE_LAST) begin
                  state_d = TRAIL;
                  sclk_d  = cpol_q;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         TRAIL: begin
            if (div_q == DIV_LAST) begin
               state_d   = IDLE;
               div_d     = '0;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               cs_n_d    = '1;
               mosi_d    = 1'b0;
               rx_data_d = rx_sr_q;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         edge_q  <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         tx_sr_q <= '0;
         rx_sr_q <= '0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         cs_n    <= '1;
         rx_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         edge_q  <= edge_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
         tx_sr_q <= tx_sr_d;
         rx_sr_q <= rx_sr_d;
         sclk    <= sclk_d;
         mosi    <= mosi_d;
         cs_n    <= cs_n_d;
         rx_data <= rx_data_d;
         busy    <= busy_d;
         done    <= done_d;
         err     <= err_d;
      end
   end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed testbench for spi_master_param (defaults: 8 bits, 3 CS, DIV=4).
// A table of transfers is driven against a behavioural SPI slave.
// Hand-written sequences cover start-while-busy, back-to-back and reset.
module tb_spi_master_param;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned NUM_CS = 3;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned DIV    = 4;

   logic              clk;
   logic              rst;
   logic              start;
   logic [1:0]        mode;
   logic              lsb_first;
   logic [SEL_W-1:0]  cs_sel;
   logic [DATA_W-1:0] tx_data;
   logic              miso;
   logic              sclk;
   logic              mosi;
   logic [NUM_CS-1:0] cs_n;
   logic [DATA_W-1:0] rx_data;
   logic              busy;
   logic              done;
   logic              err;

   int n_chk  = 0;
   int n_fail = 0;

   spi_master_param #(
      .DATA_W(DATA_W), .NUM_CS(NUM_CS), .SEL_W(SEL_W), .DIV(DIV)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .lsb_first(lsb_first),
      .cs_sel(cs_sel), .tx_data(tx_data), .miso(miso), .sclk(sclk), .mosi(mosi),
      .cs_n(cs_n), .rx_data(rx_data), .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural slave: watches sclk at negedge, shifts in the same bit order
   logic [7:0] s_tx = 8'h00;
   logic [7:0] s_rx = 8'h00;
   logic [7:0] s_seq = 8'h00;
   logic [7:0] s_edges = 8'h00;
   logic [3:0] s_jin = 4'd0;
   logic [3:0] s_jout = 4'd0;
   logic       s_miso = 1'b0;
   logic       s_act = 1'b0;
   logic       s_sclk_q = 1'b0;
   logic       lpbk = 1'b0;
   int         tog = 0;
   int         cs_multi = 0;

   assign miso = lpbk ? mosi : s_miso;

   always @(negedge clk) begin
      s_sclk_q <= sclk;
      s_act    <= (cs_n != 3'b111);
      if (sclk !== s_sclk_q) tog <= tog + 1;
      if (!$isunknown(cs_n) && ($countones(~cs_n) > 1)) cs_multi <= cs_multi + 1;
      if (cs_n != 3'b111 && !s_act) begin
         s_edges <= 8'd0;
         s_jin   <= 4'd0;
         s_rx    <= 8'h00;
         s_seq   <= 8'h00;
         if (!mode[0]) begin
            s_miso <= s_tx[lsb_first ? 3'd0 : 3'd7];
            s_jout <= 4'd1;
         end else begin
            s_jout <= 4'd0;
         end
      end else if (cs_n != 3'b111 && sclk != s_sclk_q) begin
         s_edges <= s_edges + 8'd1;
         if (s_edges[0] == mode[0]) begin
            s_seq <= {s_seq[6:0], mosi};
            s_rx[lsb_first ? s_jin[2:0] : ~s_jin[2:0]] <= mosi;
            s_jin <= s_jin + 4'd1;
         end else if (s_jout < 4'd8) begin
            s_miso <= s_tx[lsb_first ? s_jout[2:0] : ~s_jout[2:0]];
            s_jout <= s_jout + 4'd1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0] mode;
      logic       lsb;
      logic [1:0] sel;
      logic [7:0] tx;
      logic [7:0] stx;
      logic       lp;
      logic       err;
      int         done_cyc;
      logic [7:0] rx;
      logic [7:0] seq;
      logic [2:0] cs_act;
      logic       sclk_end;
      int         toggles;
   } vec_t;

   vec_t vecs[6];

   task automatic run_row(input vec_t v, input int idx);
      int cyc, done_cyc, done_n, bad, tog_base;
      logic busy1, sclk1, err1;
      logic [2:0] cs1;
      done_cyc = -1; done_n = 0; bad = 0; tog_base = tog;
      busy1 = 1'b0; sclk1 = 1'b0; err1 = 1'b0; cs1 = 3'b000;
      @(negedge clk);
      mode = v.mode; lsb_first = v.lsb; cs_sel = v.sel; tx_data = v.tx;
      s_tx = v.stx; lpbk = v.lp; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (cyc < 200) begin
         if (cyc == 1) begin busy1 = busy; sclk1 = sclk; cs1 = cs_n; end
         if (cyc == 2) tog_base = tog;
         if (done) begin
            done_n++;
            if (done_cyc < 0) begin done_cyc = cyc; err1 = err; end
         end else if (done_cyc < 0) begin
            if (busy !== !v.err || cs_n !== v.cs_act) bad++;
         end else begin
            if (busy !== 1'b0 || cs_n !== 3'b111) bad++;
         end
         if (done_cyc > 0 && cyc >= (v.err ? 12 : done_cyc)) break;
         @(posedge clk); #1;
         cyc++;
      end
      chk($sformatf("r%0d_done_cycle", idx), done_cyc, v.done_cyc);
      chk($sformatf("r%0d_done_count", idx), done_n, 1);
      chk($sformatf("r%0d_err", idx), err1, v.err);
      chk($sformatf("r%0d_rx_data", idx), rx_data, v.rx);
      chk($sformatf("r%0d_busy_c1", idx), busy1, !v.err);
      chk($sformatf("r%0d_cs_n_c1", idx), cs1, v.cs_act);
      chk($sformatf("r%0d_sclk_c1", idx), sclk1, v.sclk_end);
      chk($sformatf("r%0d_busy_cs_track", idx), bad, 0);
      chk($sformatf("r%0d_sclk_toggles", idx), tog - tog_base, v.toggles);
      chk($sformatf("r%0d_sclk_end", idx), sclk, v.sclk_end);
      chk($sformatf("r%0d_mosi_end", idx), mosi, 1'b0);
      chk($sformatf("r%0d_cs_n_end", idx), cs_n, 3'b111);
      chk($sformatf("r%0d_busy_end", idx), busy, 1'b0);
      if (!v.err) begin
         chk($sformatf("r%0d_mosi_seq", idx), s_seq, v.seq);
         chk($sformatf("r%0d_slave_rx", idx), s_rx, v.tx);
      end
   endtask

   initial begin
      int cyc, done_cyc, done_n, second, bad;

      //            mode  lsb   sel   tx     stx    lp    err   T   rx     seq    cs       sclk  tog
      vecs[0] = '{2'd0, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b1, 1'b0, 73, 8'hA5, 8'hA5, 3'b110, 1'b0, 16};
      vecs[1] = '{2'd3, 1'b0, 2'd2, 8'h5A, 8'h3C, 1'b0, 1'b0, 73, 8'h3C, 8'h5A, 3'b011, 1'b1, 16};
      vecs[2] = '{2'd1, 1'b1, 2'd0, 8'h01, 8'h80, 1'b0, 1'b0, 73, 8'h80, 8'h80, 3'b110, 1'b0, 16};
      vecs[3] = '{2'd2, 1'b1, 2'd1, 8'h01, 8'h80, 1'b0, 1'b0, 73, 8'h80, 8'h80, 3'b101, 1'b1, 16};
      vecs[4] = '{2'd0, 1'b0, 2'd3, 8'hFF, 8'h00, 1'b0, 1'b1,  1, 8'h80, 8'h00, 3'b111, 1'b1,  0};
      vecs[5] = '{2'd0, 1'b0, 2'd1, 8'hC3, 8'h96, 1'b0, 1'b0, 73, 8'h96, 8'hC3, 3'b101, 1'b0, 16};

      rst = 1'b1; start = 1'b0; mode = 2'd0; lsb_first = 1'b0;
      cs_sel = 2'd0; tx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_sclk", sclk, 1'b0);
      chk("reset_mosi", mosi, 1'b0);
      chk("reset_cs_n", cs_n, 3'b111);
      chk("reset_rx_data", rx_data, 8'h00);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_err", err, 1'b0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) run_row(vecs[i], i);

      // start pulsed mid-transfer is ignored
      @(negedge clk);
      mode = 2'd0; lsb_first = 1'b0; cs_sel = 2'd0; tx_data = 8'h33;
      s_tx = 8'h55; lpbk = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; done_cyc = -1; done_n = 0;
      while (cyc < 150) begin
         if (cyc == 20) start = 1'b1;
         if (cyc == 21) begin
            start = 1'b0;
            chk("ign_busy_c21", busy, 1'b1);
         end
         if (done) begin
            done_n++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("ign_done_count", done_n, 1);
      chk("ign_done_cycle", done_cyc, 73);
      chk("ign_rx_data", rx_data, 8'h55);

      // start held through done: back-to-back transfer with one-cycle cs_n gap
      @(negedge clk);
      mode = 2'd1; lsb_first = 1'b0; cs_sel = 2'd1; tx_data = 8'h12;
      s_tx = 8'h5A; start = 1'b1;
      @(posedge clk); #1;
      cyc = 1; done_cyc = -1; second = -1; bad = 0;
      while (cyc < 300) begin
         if (cyc == 5) tx_data = 8'h9C;
         if (done) begin
            if (done_cyc < 0) begin
               done_cyc = cyc;
               chk("b2b_cs_n_gap", cs_n, 3'b111);
               chk("b2b_busy_gap", busy, 1'b0);
               chk("b2b_slave_rx1", s_rx, 8'h12);
               chk("b2b_rx_data1", rx_data, 8'h5A);
            end else begin
               second = cyc;
               break;
            end
         end else if (done_cyc > 0 && cyc == done_cyc + 1) begin
            chk("b2b_busy_restart", busy, 1'b1);
            chk("b2b_cs_n_restart", cs_n, 3'b101);
            start = 1'b0; tx_data = 8'hFF; cs_sel = 2'd0;
         end else if (busy !== 1'b1 || cs_n !== 3'b101) begin
            bad++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      chk("b2b_done1_cycle", done_cyc, 73);
      chk("b2b_done2_cycle", second, 146);
      chk("b2b_slave_rx2", s_rx, 8'h9C);
      chk("b2b_rx_data2", rx_data, 8'h5A);
      chk("b2b_busy_cs_track", bad, 0);

      // reset in the middle of a mode-2 transfer
      @(negedge clk);
      mode = 2'd2; lsb_first = 1'b0; cs_sel = 2'd0; tx_data = 8'hF0;
      s_tx = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("rst_busy_before", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_sclk", sclk, 1'b0);
      chk("rst_cs_n", cs_n, 3'b111);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_mosi", mosi, 1'b0);
      rst = 1'b0;
      done_n = 0;
      for (int k = 0; k < 100; k++) begin
         if (done) done_n++;
         @(posedge clk); #1;
      end
      chk("rst_no_done", done_n, 0);

      chk("cs_n_onehot", cs_multi, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
